muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for the iterative MUL/UMULL/SMULL/DIV operations decoded as ALUControl 4'b0100..4'b0111.
//  Runs shift-add multiply or restoring divide over WIDTH iterations; holds busy so the main FSM stalls in its execute state.
//  Registers a 2*WIDTH result (lo/hi) for the writeback path: RdLo/RdHi on long multiplies, quotient/remainder on DIV.
// PARAMETERS
//  WIDTH  32  operand width; product and remainder/quotient pair are 2*WIDTH
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low (0 = reset)
//  start        in   1        launch request; sampled only in IDLE or DONE
//  op           in   2        00 MUL, 01 UMULL, 10 SMULL, 11 DIV (= ALUControl[1:0] of 4'b01xx)
//  abort        in   1        cancel in-flight operation
//  src_a        in   WIDTH    multiplicand / dividend
//  src_b        in   WIDTH    multiplier / divisor
//  busy         out  1        high in CALC and FIX
//  done         out  1        one-cycle pulse, result valid
//  div_by_zero  out  1        set with done when op=DIV and src_b==0
//  result_lo    out  WIDTH    product[W-1:0] / quotient
//  result_hi    out  WIDTH    product[2W-1:W] / remainder (0 for MUL)
// BEHAVIOUR
//  - Reset (reset=0, any time, incl. mid-op): state=IDLE; busy, done, div_by_zero, result_lo, result_hi, counters = 0.
//  - States: IDLE, CALC, FIX, DONE. E0 = edge sampling start.
//    IDLE/DONE + start: latch op, operands, sign info -> CALC (E0). DONE without start -> IDLE.
//    DIV with src_b==0 at E0: -> DONE directly; result_lo=all ones, result_hi=src_a, div_by_zero=1.
//    CALC: one iteration per cycle; after N iterations -> FIX; N = WIDTH.
//    FIX: sign correction, load result regs -> DONE. done=1 only in DONE (one cycle after edge E0+N+1).
//  - start while busy ignored. start in DONE starts the next op back-to-back; done still pulses exactly one cycle.
//  - abort in CALC/FIX: -> IDLE next edge; results unchanged; no done. abort in IDLE/DONE ignored; abort wins over start.
//  - Multiply: acc(2W) += mcand(2W) when mplier[0]; mcand <<= 1; mplier >>= 1.
//    SMULL: operands converted to magnitudes at E0; FIX negates 2W product (two's complement) if signs differ.
//    MUL: result_lo = low W bits, result_hi = 0. UMULL: unsigned, no correction.
//  - DIV (unsigned, restoring): rem = {rem[W-2:0], dvd[W-1]}; if rem >= divisor, rem -= divisor and q bit = 1; dvd <<= 1.
//  - All arithmetic is modulo 2^(2W); no overflow flag produced.
//  - Results held stable from DONE until the next FIX, reset, or DIV-by-zero load.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: multiply ops leave CALC on the iteration whose next mplier value is 0, so
//   N = (bit index of MSB of |src_b|)+1, minimum 1 (src_b==0 -> N=1). DIV is unaffected (N=WIDTH).
//  Not defined: every op takes N=WIDTH; latency fixed at WIDTH+2 edges E0..done.
// TESTING
//  UMULL 0xFFFFFFFF*0xFFFFFFFF -> done after E0+33, hi=0xFFFFFFFE lo=0x00000001, busy high 33 cycles.
//  SMULL 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; MUL 0x10000*0x10000 -> lo=0, hi=0.
//  DIV 100/7 -> lo=14 hi=2 div_by_zero=0; DIV 5/0 -> done at E0+1, lo=0xFFFFFFFF hi=5 div_by_zero=1.
//  UMULL started, abort at 10th CALC cycle -> busy=0 next cycle, no done, results keep prior values; next start completes.
//  reset=0 asserted mid-CALC -> all outputs 0 immediately (async); start after release runs normally.
//  MULDIV_EARLY_OUT_EN: MUL 5*3 -> N=2, done after E0+3, lo=15; same op without macro -> done after E0+33.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider for MUL, UMULL, SMULL and DIV.
// Define MULDIV_EARLY_OUT_EN to let multiplies stop once the remaining multiplier bits are zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod;
    logic               last_iter;

    // For DIV the datapath is reused: acc_q low half holds the remainder,
    // mcand_q low half the divisor, and mplier_q shifts the dividend out while the quotient shifts in.
    always_comb begin
        mag_a     = src_a[WIDTH-1] ? -src_a : src_a;
        mag_b     = src_b[WIDTH-1] ? -src_b : src_b;
        rem_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, mcand_q[WIDTH-1:0]};
        rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - mcand_q[WIDTH-1:0]) : rem_shift[WIDTH-1:0];
        prod      = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_EARLY_OUT_EN
        last_iter = (cnt_q == CW'(WIDTH - 1)) ||
                    ((op_q != OP_DIV) && ((mplier_q >> 1) == '0));
`else
        last_iter = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    acc_d = '0;
                    neg_d = (op == OP_SMULL) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    if (op == OP_DIV && src_b == '0) begin
                        state_d  = S_DONE;
                        res_lo_d = '1;
                        res_hi_d = src_a;
                        done_d   = 1'b1;
                        dbz_d    = 1'b1;
                    end else if (op == OP_DIV) begin
                        state_d  = S_CALC;
                        mcand_d  = {{WIDTH{1'b0}}, src_b};
                        mplier_d = src_a;
                    end else begin
                        state_d  = S_CALC;
                        mcand_d  = {{WIDTH{1'b0}}, (op == OP_SMULL) ? mag_a : src_a};
                        mplier_d = (op == OP_SMULL) ? mag_b : src_b;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q == OP_DIV) begin
                        acc_d    = {{WIDTH{1'b0}}, rem_next};
                        mplier_d = {mplier_q[WIDTH-2:0], rem_ge};
                    end else begin
                        if (mplier_q[0]) acc_d = acc_q + mcand_q;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_DIV: begin
                            res_lo_d = mplier_q;
                            res_hi_d = acc_q[WIDTH-1:0];
                        end
                        OP_MUL: begin
                            res_lo_d = prod[WIDTH-1:0];
                            res_hi_d = '0;
                        end
                        default: begin
                            res_lo_d = prod[WIDTH-1:0];
                            res_hi_d = prod[2*WIDTH-1:WIDTH];
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;

endmodule
